aux_uart_tx: RTL and testbench

AUX_UART_TX -- requirements
Module: aux_uart_tx

---
 rtl/aux_uart_pkg.sv | 15 +
 rtl/aux_uart_fifo.sv | 55 +++++
 rtl/aux_uart_tx.sv | 141 ++++++++++++++
 tb/tb_aux_uart_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aux_uart_pkg.sv
// Shared definitions for the aux UART transmitter and receiver.
// Frame shape (8N1) and the bit-level state encoding live here.
package aux_uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/aux_uart_fifo.sv
// Small synchronous FIFO with a registered occupancy count.
// Read data is the current head entry and needs no pop to appear.
module aux_uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_depth_check
    $error("aux_uart_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (count_q != (PW + 1)'(DEPTH));
  assign do_pop   = pop && (count_q != '0);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/aux_uart_tx.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are shifted out LSB first.
// tx is registered from the current state, so the line lags the FSM by one clock.
module aux_uart_tx
  import aux_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 50000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  if (DIV < 2) begin : gen_div_check
    $error("aux_uart_tx: CLK_FREQUENCY / BAUD_RATE must be at least 2");
  end

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 baud_last;
  logic [DATA_BITS-1:0] fifo_data;

  assign in_ready   = (fifo_count != ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_count == '0);
  assign baud_last  = (baud_q == BAUD_LAST);
  assign tx         = tx_q;

  aux_uart_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(in_data),
    .pop      (pop),
    .pop_data (fifo_data),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    busy = (state_q != IDLE) || !fifo_empty;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[idx_q];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_aux_uart_tx.sv
// Bench for aux_uart_tx: accepted bytes go into a scoreboard queue and a model
// receiver sampling tx at mid-bit pops and compares each recovered frame.
module tb_aux_uart_tx;

  localparam int unsigned CLK_FREQUENCY = 1000;
  localparam int unsigned BAUD_RATE     = 100;
  localparam int unsigned FIFO_DEPTH    = 4;
  localparam int unsigned DIV           = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  aux_uart_tx #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .BAUD_RATE    (BAUD_RATE),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         fall_q[$];
  int         cyc = 0;
  bit         rx_active = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_byte;
  logic       rx_start;
  logic       rx_stop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge: present inputs, log the byte if it will be accepted, land on next negedge.
  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = v ? d : 8'($urandom);
    if (v && in_ready && !reset) exp_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || rx_active) && n < limit) begin
      drive(1'b0, 8'h00);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (3) drive(1'b0, 8'h00);
  endtask

  // Model receiver: a frame starts at the first low sample; bit j is sampled mid-period.
  initial begin
    int j;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset === 1'b1) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1'b1;
          rx_t      = 0;
          fall_q.push_back(cyc);
        end
      end else begin
        rx_t++;
      end
      if (rx_active && (rx_t % DIV) == DIV / 2 - 1) begin
        j = rx_t / DIV;
        if (j == 0) begin
          rx_start = tx;
        end else if (j <= 8) begin
          rx_byte[j-1] = tx;
        end else begin
          rx_stop   = tx;
          rx_active = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got frame %0h expected none", rx_byte);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", rx_byte, e);
            chk("rx_framing", {rx_stop, rx_start}, 2'b10);
          end
        end
      end
    end
  end

  initial begin
    logic [9:0] frame;
    logic [7:0] six[6];
    int         tx_bad, busy_bad, rdy_bad, k, n, acc, nfall;
    bit         saw_full, v, was_ready;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    chk("reset_tx", tx, 1);
    chk("reset_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_count", fifo_count, 0);

    // Single 0xA5 frame: exact waveform and latency.
    drive(1'b1, 8'hA5);
    chk("a5_count_after_push", fifo_count, 1);
    chk("a5_busy_after_push", busy, 1);
    chk("a5_tx_edge_n", tx, 1);
    drive(1'b0, 8'h00);
    chk("a5_tx_edge_n1", tx, 1);
    drive(1'b0, 8'h00);
    frame    = {1'b1, 8'hA5, 1'b0};
    tx_bad   = 0;
    busy_bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (tx !== frame[c / DIV]) tx_bad++;
      if (c < 98 && busy !== 1'b1) busy_bad++;
      drive(1'b0, 8'h00);
    end
    chk("a5_waveform_errs", tx_bad, 0);
    chk("a5_busy_held_errs", busy_bad, 0);
    chk("a5_busy_after_frame", busy, 0);
    chk("a5_tx_after_frame", tx, 1);
    wait_idle(500);

    // Back-to-back frames with no idle gap.
    fall_q.delete();
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hFF);
    drive(1'b1, 8'h55);
    wait_idle(1000);
    chk("b2b_frames", fall_q.size(), 3);
    if (fall_q.size() == 3) begin
      chk("b2b_gap_1", fall_q[1] - fall_q[0], 100);
      chk("b2b_gap_2", fall_q[2] - fall_q[1], 100);
    end

    // Hold in_valid with six distinct bytes; back-pressure at full.
    six      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
    k        = 0;
    n        = 0;
    rdy_bad  = 0;
    saw_full = 1'b0;
    while (k < 6 && n < 1000) begin
      if (in_ready !== (fifo_count != 3'd4)) rdy_bad++;
      if (fifo_count == 3'd4 && in_ready === 1'b0) saw_full = 1'b1;
      was_ready = in_ready;
      drive(1'b1, six[k]);
      if (was_ready) k++;
      n++;
    end
    chk("hold_accepted", k, 6);
    chk("hold_ready_rule_errs", rdy_bad, 0);
    chk("hold_saw_full", saw_full, 1);
    wait_idle(1000);

    // Push lands on the very edge the FSM pops the next byte at count 2.
    drive(1'b1, 8'hA1);
    drive(1'b1, 8'hB2);
    drive(1'b1, 8'hC3);
    repeat (98) drive(1'b0, 8'h00);
    chk("simul_count_before", fifo_count, 2);
    drive(1'b1, 8'hD4);
    chk("simul_count_after", fifo_count, 2);
    wait_idle(1000);

    // Random traffic with bursty gaps.
    acc = 0;
    n   = 0;
    while (acc < 200 && n < 40000) begin
      v = ($urandom_range(0, 7) < (((n / 500) % 2) ? 2 : 7));
      if (v && in_ready) acc++;
      drive(v, 8'($urandom));
      n++;
    end
    chk("rand_accepted", acc, 200);
    wait_idle(2000);
    chk("rand_all_received", exp_q.size(), 0);

    // Reset 35 cycles into a frame with two bytes queued.
    drive(1'b1, 8'hE1);
    drive(1'b1, 8'hE2);
    drive(1'b1, 8'hE3);
    repeat (35) drive(1'b0, 8'h00);
    chk("midreset_count_before", fifo_count, 2);
    reset = 1'b1;
    exp_q.delete();
    drive(1'b1, 8'h99);
    #1 reset = 1'b0;
    chk("midreset_tx", tx, 1);
    chk("midreset_count", fifo_count, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", in_ready, 1);
    nfall  = fall_q.size();
    tx_bad = 0;
    for (int c = 0; c < 300; c++) begin
      if (tx !== 1'b1) tx_bad++;
      drive(1'b0, 8'h00);
    end
    chk("midreset_line_idle_errs", tx_bad, 0);
    chk("midreset_no_frames", fall_q.size(), nfall);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
